// File: rtl/control_fsm_pkg.sv
// Shared constants for the WF8 control sequencer: state encodings, opcodes,
// one-hot ALU mode indices and the decoder result bundle.
package control_fsm_pkg;

    localparam int unsigned WF8_OPCODE_W  = 5;
    localparam int unsigned WF8_ALU_MODES = 6;
    localparam int unsigned STATE_W       = 3;

    localparam int unsigned ALU_ADD      = 0;
    localparam int unsigned ALU_SHIFT    = 1;
    localparam int unsigned ALU_NOT      = 2;
    localparam int unsigned ALU_AND      = 3;
    localparam int unsigned ALU_OR       = 4;
    localparam int unsigned ALU_BYPASS_A = 5;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] S_EXEC   = 3'd3;
    localparam logic [STATE_W-1:0] S_MEM    = 3'd4;
    localparam logic [STATE_W-1:0] S_FAULT  = 3'd5;
    localparam logic [STATE_W-1:0] S_HALT   = 3'd6;

    localparam logic [WF8_OPCODE_W-1:0] OP_ADD    = 5'b00000;
    localparam logic [WF8_OPCODE_W-1:0] OP_ADDI   = 5'b00010;
    localparam logic [WF8_OPCODE_W-1:0] OP_SH     = 5'b00100;
    localparam logic [WF8_OPCODE_W-1:0] OP_SHI    = 5'b00110;
    localparam logic [WF8_OPCODE_W-1:0] OP_NOT    = 5'b01000;
    localparam logic [WF8_OPCODE_W-1:0] OP_AND    = 5'b01010;
    localparam logic [WF8_OPCODE_W-1:0] OP_OR     = 5'b01100;
    localparam logic [WF8_OPCODE_W-1:0] OP_CPY    = 5'b10000;
    localparam logic [WF8_OPCODE_W-1:0] OP_CPYPC  = 5'b10001;
    localparam logic [WF8_OPCODE_W-1:0] OP_LB     = 5'b10010;
    localparam logic [WF8_OPCODE_W-1:0] OP_SB     = 5'b10100;
    localparam logic [WF8_OPCODE_W-1:0] OP_JMPADR = 5'b10110;
    localparam logic [WF8_OPCODE_W-1:0] OP_JMPI   = 5'b11000;
    localparam logic [WF8_OPCODE_W-1:0] OP_BLT    = 5'b11001;
    localparam logic [WF8_OPCODE_W-1:0] OP_BGE    = 5'b11010;
    localparam logic [WF8_OPCODE_W-1:0] OP_BEQ    = 5'b11011;
    localparam logic [WF8_OPCODE_W-1:0] OP_BNEQ   = 5'b11100;
    localparam logic [WF8_OPCODE_W-1:0] OP_HALT   = 5'b11111;

    typedef struct packed {
        logic [WF8_ALU_MODES-1:0] alu_mode;
        logic                     alu_a_sel;
        logic                     alu_b_sel;
        logic                     is_alu;
        logic                     is_load;
        logic                     is_store;
        logic                     is_jump;
        logic                     is_branch;
        logic                     is_halt;
    } ctrl_decode_t;

    function automatic logic [WF8_ALU_MODES-1:0] alu_onehot(input int unsigned idx);
        return WF8_ALU_MODES'(1) << idx;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decode: latched opcode -> ALU controls and
// instruction class flags used by the sequencer.
module control_decode
    import control_fsm_pkg::*;
(
    input  logic [WF8_OPCODE_W-1:0]  op_q,
    output logic [WF8_ALU_MODES-1:0] alu_mode,
    output logic                     alu_a_sel,
    output logic                     alu_b_sel,
    output logic                     is_alu,
    output logic                     is_load,
    output logic                     is_store,
    output logic                     is_jump,
    output logic                     is_branch,
    output logic                     is_halt
);

    // ADD covers add/addi, 0111 and every 11xx PC-relative form
    always_comb begin
        alu_mode = alu_onehot(ALU_ADD);
        casez (op_q[4:1])
            4'b001?: alu_mode = alu_onehot(ALU_SHIFT);
            4'b0100: alu_mode = alu_onehot(ALU_NOT);
            4'b0101: alu_mode = alu_onehot(ALU_AND);
            4'b0110: alu_mode = alu_onehot(ALU_OR);
            4'b10??: alu_mode = alu_onehot(ALU_BYPASS_A);
            default: alu_mode = alu_onehot(ALU_ADD);
        endcase
    end

    assign alu_a_sel = (op_q[4:3] == 2'b11) || (op_q == OP_CPYPC);
    assign alu_b_sel = (op_q[4:3] == 2'b11) || ((op_q[4:3] == 2'b00) && op_q[1]);

    // cpy/cpypc write the register file exactly like ALU ops
    assign is_alu    = !op_q[4] || (op_q[4:1] == 4'b1000);
    assign is_load   = (op_q[4:1] == OP_LB[4:1]);
    assign is_store  = (op_q[4:1] == OP_SB[4:1]);
    assign is_jump   = (op_q[4:1] == OP_JMPADR[4:1]) || (op_q == OP_JMPI);
    assign is_branch = (op_q >= OP_BLT) && (op_q <= OP_BNEQ);
    assign is_halt   = (op_q == OP_HALT);

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle WF8 control sequencer: fetch/decode/exec/mem over a req/ack port
// with timeout fault. Define CONTROL_HALT_EN to make opcode 11111 halt the core.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned OPCODE_W       = 5,
    parameter int unsigned ALU_MODE_COUNT = 6,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPCODE_W-1:0]       opcode,
    input  logic                      branch_taken,
    input  logic                      mem_ack,
    output logic                      mem_req,
    output logic                      mem_write_en,
    output logic                      mem_addr_sel,
    output logic                      ir_write_en,
    output logic                      pc_inc,
    output logic                      pc_write_en,
    output logic [ALU_MODE_COUNT-1:0] alu_mode,
    output logic                      alu_a_sel,
    output logic                      alu_b_sel,
    output logic                      rf_write_en,
    output logic [2:0]                state,
    output logic                      fault
);

    if (OPCODE_W != WF8_OPCODE_W) begin : g_bad_opcode_w
        $error("control_fsm: OPCODE_W must be 5");
    end
    if (ALU_MODE_COUNT != WF8_ALU_MODES) begin : g_bad_alu_modes
        $error("control_fsm: ALU_MODE_COUNT must be 6");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("control_fsm: TIMEOUT_CYCLES must be at least 1");
    end

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0]      state_q, state_d;
    logic [WF8_OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fault_q, fault_d;
    ctrl_decode_t            dec;

    control_decode u_decode (
        .op_q      (op_q),
        .alu_mode  (dec.alu_mode),
        .alu_a_sel (dec.alu_a_sel),
        .alu_b_sel (dec.alu_b_sel),
        .is_alu    (dec.is_alu),
        .is_load   (dec.is_load),
        .is_store  (dec.is_store),
        .is_jump   (dec.is_jump),
        .is_branch (dec.is_branch),
        .is_halt   (dec.is_halt)
    );

    // State, latched opcode, wait counter and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Next state and per-state strobe gating; counter restarts unless still waiting
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = '0;
        fault_d      = fault_q;
        mem_req      = 1'b0;
        mem_write_en = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write_en  = 1'b0;
        pc_inc       = 1'b0;
        pc_write_en  = 1'b0;
        alu_mode     = '0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_write_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write_en = 1'b1;
                    pc_inc      = 1'b1;
                    state_d     = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DECODE: begin
                op_d    = opcode[WF8_OPCODE_W-1:0];
                state_d = S_EXEC;
            end

            S_EXEC: begin
                alu_mode  = ALU_MODE_COUNT'(dec.alu_mode);
                alu_a_sel = dec.alu_a_sel;
                alu_b_sel = dec.alu_b_sel;
                state_d   = S_FETCH;
                if (dec.is_alu) begin
                    rf_write_en = 1'b1;
                end else if (dec.is_jump) begin
                    pc_write_en = 1'b1;
                end else if (dec.is_branch) begin
                    pc_write_en = branch_taken;
                end else if (dec.is_load || dec.is_store) begin
                    state_d = S_MEM;
                end else if (dec.is_halt) begin
`ifdef CONTROL_HALT_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end
            end

            // ALU keeps computing the effective address while the access is open
            S_MEM: begin
                alu_mode     = ALU_MODE_COUNT'(dec.alu_mode);
                alu_a_sel    = dec.alu_a_sel;
                alu_b_sel    = dec.alu_b_sel;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_write_en = dec.is_store;
                if (mem_ack) begin
                    rf_write_en = dec.is_load;
                    state_d     = S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized self-checking bench for control_fsm: an instruction-level model
// expands each instruction into its expected per-cycle control trace.
module tb_control_fsm;

    localparam int TO = 15;
`ifdef CONTROL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       mwe;
        logic       mas;
        logic       irw;
        logic       pci;
        logic       pcw;
        logic [5:0] am;
        logic       aas;
        logic       bsel;
        logic       rfw;
        logic       flt;
    } obs_t;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic       branch_taken;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_write_en;
    logic       mem_addr_sel;
    logic       ir_write_en;
    logic       pc_inc;
    logic       pc_write_en;
    logic [5:0] alu_mode;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       rf_write_en;
    logic [2:0] state;
    logic       fault;

    int   vectors   = 0;
    int   errors    = 0;
    int   rf_pulses = 0;
    int   pc_pulses = 0;
    obs_t exp_cur;
    bit   exp_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    control_fsm #(
        .OPCODE_W       (5),
        .ALU_MODE_COUNT (6),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_write_en (mem_write_en),
        .mem_addr_sel (mem_addr_sel),
        .ir_write_en  (ir_write_en),
        .pc_inc       (pc_inc),
        .pc_write_en  (pc_write_en),
        .alu_mode     (alu_mode),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .rf_write_en  (rf_write_en),
        .state        (state),
        .fault        (fault)
    );

    // ALU operation from opcode value ranges
    function automatic logic [5:0] ref_alu(input logic [4:0] op);
        int v;
        v = int'(op);
        if (v < 4)  return 6'b000001;
        if (v < 8)  return 6'b000010;
        if (v < 10) return 6'b000100;
        if (v < 12) return 6'b001000;
        if (v < 14) return 6'b010000;
        if (v < 16) return 6'b000001;
        if (v < 24) return 6'b100000;
        return 6'b000001;
    endfunction

    function automatic logic ref_asel(input logic [4:0] op);
        return (int'(op) >= 24) || (int'(op) == 17);
    endfunction

    function automatic logic ref_bsel(input logic [4:0] op);
        return (int'(op) >= 24) || ((int'(op) < 8) && op[1]);
    endfunction

    function automatic obs_t rec(input logic [2:0] st);
        obs_t r;
        r    = '0;
        r.st = st;
        return r;
    endfunction

    function automatic logic [4:0] rnd5();
        return 5'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // One cycle: drive inputs on the falling edge and publish the expectation
    task automatic cycle(input obs_t e, input logic ack, input logic [4:0] opc,
                         input logic bt, input logic r);
        @(negedge clk);
        rst          = r;
        mem_ack      = ack;
        opcode       = opc;
        branch_taken = bt;
        exp_cur      = e;
        exp_valid    = 1'b1;
    endtask

    // Compare process: every cycle, mid-low-phase
    initial begin
        obs_t got;
        forever begin
            @(negedge clk);
            #2;
            if (exp_valid) begin
                got = {state, mem_req, mem_write_en, mem_addr_sel, ir_write_en, pc_inc,
                       pc_write_en, alu_mode, alu_a_sel, alu_b_sel, rf_write_en, fault};
                vectors++;
                if (got !== exp_cur) begin
                    errors++;
                    $display("FAIL cycle_check t=%0t: state got %0d expected %0d, outputs got %h expected %h",
                             $time, got.st, exp_cur.st, got, exp_cur);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rf_write_en === 1'b1) rf_pulses++;
            if (pc_inc === 1'b1) pc_pulses++;
        end
    end

    task automatic do_reset();
        cycle(rec(ST_IDLE), rnd1(), rnd5(), rnd1(), 1'b1);
        cycle(rec(ST_IDLE), rnd1(), rnd5(), rnd1(), 1'b1);
        cycle(rec(ST_IDLE), rnd1(), rnd5(), rnd1(), 1'b0);
    endtask

    // outcome: 0 completed, 1 timed out, 2 halted, 3 reset during MEM
    task automatic run_instr(input logic [4:0] op, input int fw, input int mw,
                             input int btm, input bit rst_mid, output int outcome);
        obs_t e;
        logic bt;
        int   v;
        bit   is_ld;
        bit   is_st;
        v       = int'(op);
        is_ld   = (v == 18) || (v == 19);
        is_st   = (v == 20) || (v == 21);
        outcome = 0;

        for (int i = 0; i < fw && i < TO; i++) begin
            e = rec(ST_FETCH); e.req = 1'b1;
            cycle(e, 1'b0, rnd5(), rnd1(), 1'b0);
        end
        if (fw >= TO) begin
            outcome = 1;
            return;
        end
        e = rec(ST_FETCH); e.req = 1'b1; e.irw = 1'b1; e.pci = 1'b1;
        cycle(e, 1'b1, rnd5(), rnd1(), 1'b0);

        cycle(rec(ST_DECODE), rnd1(), op, rnd1(), 1'b0);

        bt = (btm == 2) ? rnd1() : 1'(btm);
        e = rec(ST_EXEC);
        e.am = ref_alu(op); e.aas = ref_asel(op); e.bsel = ref_bsel(op);
        if (v < 18) e.rfw = 1'b1;
        if (v >= 22 && v <= 24) e.pcw = 1'b1;
        if (v >= 25 && v <= 28) e.pcw = bt;
        cycle(e, rnd1(), rnd5(), bt, 1'b0);

        if (HALT_EN && v == 31) begin
            outcome = 2;
            return;
        end
        if (!(is_ld || is_st)) return;

        e = rec(ST_MEM);
        e.req = 1'b1; e.mas = 1'b1; e.mwe = is_st;
        e.am = ref_alu(op); e.aas = ref_asel(op); e.bsel = ref_bsel(op);
        for (int i = 0; i < mw && i < TO; i++) begin
            cycle(e, 1'b0, rnd5(), rnd1(), 1'b0);
            if (rst_mid) begin
                cycle(rec(ST_IDLE), 1'b1, rnd5(), rnd1(), 1'b1);
                outcome = 3;
                return;
            end
        end
        if (mw >= TO) begin
            outcome = 1;
            return;
        end
        e.rfw = is_ld;
        cycle(e, 1'b1, rnd5(), rnd1(), 1'b0);
    endtask

    // Absorbing FAULT/HALT phases (acks ignored), then recover through reset
    task automatic settle(input int outcome);
        obs_t e;
        if (outcome == 1) begin
            e = rec(ST_FAULT); e.flt = 1'b1;
            for (int i = 0; i < 4; i++) cycle(e, rnd1(), rnd5(), rnd1(), 1'b0);
        end else if (outcome == 2) begin
            for (int i = 0; i < 4; i++) cycle(rec(ST_HALT), rnd1(), rnd5(), rnd1(), 1'b0);
        end
        if (outcome != 0) do_reset();
    endtask

    int oc;
    int r0;
    int p0;

    initial begin
        rst          = 1'b1;
        mem_ack      = 1'b0;
        opcode       = '0;
        branch_taken = 1'b0;

        chk("pin_alu_addi", int'(ref_alu(5'b00010)), 1);
        chk("pin_alu_lb", int'(ref_alu(5'b10010)), 32);
        chk("pin_alu_or", int'(ref_alu(5'b01100)), 16);
        chk("pin_alu_sh", int'(ref_alu(5'b00100)), 2);
        chk("pin_bsel_beq", int'(ref_bsel(5'b11011)), 1);
        chk("pin_bsel_add", int'(ref_bsel(5'b00000)), 0);
        chk("pin_asel_cpypc", int'(ref_asel(5'b10001)), 1);

        do_reset();

        r0 = rf_pulses; p0 = pc_pulses;
        run_instr(5'b00010, 0, 0, 2, 1'b0, oc);
        #4;
        chk("addi_rf_pulses", rf_pulses - r0, 1);
        chk("addi_pc_inc_pulses", pc_pulses - p0, 1);

        r0 = rf_pulses;
        run_instr(5'b10010, 0, 3, 2, 1'b0, oc);
        #4;
        chk("lb_rf_pulses", rf_pulses - r0, 1);

        r0 = rf_pulses;
        run_instr(5'b10100, 1, 2, 2, 1'b0, oc);
        #4;
        chk("sb_rf_pulses", rf_pulses - r0, 0);

        run_instr(5'b11011, 0, 0, 0, 1'b0, oc);
        run_instr(5'b11011, 0, 0, 1, 1'b0, oc);
        run_instr(5'b11000, 0, 0, 0, 1'b0, oc);
        run_instr(5'b10110, 0, 0, 2, 1'b0, oc);
        run_instr(5'b10001, 0, 0, 2, 1'b0, oc);
        run_instr(5'b11101, 0, 0, 1, 1'b0, oc);
        run_instr(5'b11110, 0, 0, 1, 1'b0, oc);

        run_instr(5'b00010, TO - 1, 0, 2, 1'b0, oc);
        run_instr(5'b10011, 0, TO - 1, 2, 1'b0, oc);

        run_instr(5'b00000, TO, 0, 2, 1'b0, oc);
        chk("fetch_timeout_outcome", oc, 1);
        settle(oc);

        run_instr(5'b10010, 0, TO, 2, 1'b0, oc);
        chk("mem_timeout_outcome", oc, 1);
        settle(oc);

        run_instr(5'b10100, 0, 2, 2, 1'b1, oc);
        settle(oc);

        run_instr(5'b11111, 0, 0, 1, 1'b0, oc);
        chk("op11111_outcome", oc, HALT_EN ? 2 : 0);
        settle(oc);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] op;
            int         fw;
            int         mw;
            int         pick;
            bit         rm;
            op   = rnd5();
            pick = $urandom_range(0, 99);
            fw   = (pick < 80) ? $urandom_range(0, 2) :
                   (pick < 96) ? $urandom_range(3, TO - 1) : TO;
            pick = $urandom_range(0, 99);
            mw   = (pick < 80) ? $urandom_range(0, 2) :
                   (pick < 96) ? $urandom_range(3, TO - 1) : TO;
            rm   = (mw >= 1) && ($urandom_range(0, 99) < 3);
            run_instr(op, fw, mw, 2, rm, oc);
            settle(oc);
        end

        @(negedge clk);
        exp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle control sequencer for the WF8 8-bit core; successor to the single-cycle combinational decoder.
- Sequences instruction fetch, decode, execute and memory access over a req/ack memory handshake.
- Gates register-file, PC and memory writes per state, conditions branches on the isolated branch comparator, and faults on memory timeout.
- Sits between the instruction register, ALU, register file, PC and memory port.

Parameters:
OPCODE_W, 5, opcode width; only 5 is supported, asserted at elaboration.
ALU_MODE_COUNT, 6, width of one-hot alu_mode (ADD, SHIFT, NOT, AND, OR, BYPASS_A).
TIMEOUT_CYCLES, 15, max wait cycles for mem_ack in FETCH/MEM before fault; must be at least 1.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
opcode  in  OPCODE_W  opcode field from instruction register, valid from cycle after ir_write_en
branch_taken  in  1  branch comparator result, valid in EXEC
mem_ack  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ack
mem_write_en  out  1  request is a store (sb)
mem_addr_sel  out  1  0 = PC address (fetch), 1 = ALU result (lb/sb)
ir_write_en  out  1  load instruction register (fetch ack cycle)
pc_inc  out  1  PC += 1 (fetch ack cycle)
pc_write_en  out  1  PC <= ALU result (taken jump/branch)
alu_mode  out  ALU_MODE_COUNT  one-hot ALU operation
alu_a_sel  out  1  0 = accumulator, 1 = PC
alu_b_sel  out  1  0 = register x0..x6, 1 = immediate
rf_write_en  out  1  register-file write strobe
state  out  3  current state encoding, for debug
fault  out  1  sticky memory-timeout flag

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, FAULT=5, HALT=6.
- Reset, asynchronous: state=IDLE, op_q=0, wait counter=0, fault=0. All outputs 0 while in reset and in IDLE.
- IDLE -> FETCH unconditionally on the next clock.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ack=1: ir_write_en=1 and pc_inc=1 for that cycle only; next state DECODE.
- DECODE: op_q <= opcode; no strobes; next state EXEC.
- Every control output is decoded from state and op_q only, never from the raw opcode input.
- Decode of op_q[4:1] to alu_mode:
  - 000x ADD (add/addi); 001x SHIFT (sh/shi); 0100 NOT; 0101 AND; 0110 OR; 0111 ADD.
  - 10xx BYPASS_A (1000x cpy/cpypc, 1001 lb, 1010 sb, 1011 jmpadr).
  - 11xx ADD.
- alu_a_sel=1 for op_q[4:3]=11 or op_q=10001. alu_b_sel=1 for op_q[4:3]=11, or op_q[4:3]=00 with op_q[1]=1.
- EXEC:
  - ALU ops (0xxxx) and cpy/cpypc: rf_write_en=1, next state FETCH.
  - jmpadr (1011x): pc_write_en=1, next state FETCH.
  - 11000 jmpi: pc_write_en=1. 11001 blt, 11010 bge, 11011 beq, 11100 bneq: pc_write_en=branch_taken. All go to FETCH.
  - 11101..11111 reserved: no strobes, next state FETCH.
  - lb/sb: next state MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_write_en=1 for sb only. On mem_ack: rf_write_en=1 for lb in the same cycle; next state FETCH.
- Minimum latency: ALU op 3 cycles; lb/sb 4 cycles (with mem_ack asserted immediately).
- Wait counter: cleared on entering FETCH/MEM, increments each cycle without ack.
  - mem_ack in the cycle the count equals TIMEOUT_CYCLES-1 still succeeds.
  - Otherwise the FSM moves to FAULT, fault <= 1, mem_req drops. FAULT is absorbing until rst.
- mem_ack outside FETCH/MEM is ignored.
- Reset mid-request: mem_req and all strobes go low immediately; no partial store strobe survives.

Optional Feature:
- Macro CONTROL_HALT_EN.
- Defined: op_q=11111 in EXEC moves to HALT. HALT drives all outputs 0 except state; exits only on rst.
- Undefined: 11111 is a reserved no-op per EXEC rules; HALT state is unreachable.

Decomposition:
- Shared header (param.vh): ALU_MODE_COUNT, one-hot ALU_MODE_* indices, state encodings, opcode constants (OP_LB, OP_SB, OP_JMPI, OP_HALT ...).
- One combinational sub-module, control_decode: op_q -> alu_mode, alu_a_sel, alu_b_sel, class flags (is_alu, is_load, is_store, is_jump, is_branch, is_halt).
- control_fsm holds state, op_q, wait counter and the strobe gating.

Test Plan:
- Reset then opcode 00010 (addi), mem_ack held 1 -> IDLE,FETCH,DECODE,EXEC; EXEC shows alu_mode=ADD, alu_b_sel=1, rf_write_en=1 for exactly 1 cycle; pc_inc once.
- Opcode 10010 (lb), mem_ack delayed 3 cycles in MEM -> mem_req=1, mem_addr_sel=1, mem_write_en=0 for 4 cycles; rf_write_en only on the ack cycle.
- Opcode 10100 (sb) -> mem_write_en=1 throughout MEM; rf_write_en never asserted.
- Opcode 11011 (beq) with branch_taken=0, then again with branch_taken=1 -> pc_write_en 0, then 1; alu_a_sel=1, alu_b_sel=1, alu_mode=ADD.
- FETCH with mem_ack=0 for 15 cycles -> FAULT, fault=1, mem_req=0; later mem_ack ignored; rst clears fault.
- Opcode 11111 with CONTROL_HALT_EN -> state=HALT, outputs 0. Without the macro -> returns to FETCH with no strobes.
